// File: rtl/sig_debounce_pkg.sv
// sig_debounce shared types and defaults.
// FSM state encoding plus default parameter values.
package sig_debounce_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_t;

endpackage

// File: rtl/sig_sync.sv
// sig_sync: multi-flop synchronizer for one async level.
// All flops reset to 0; q is the last flop.
module sig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the raw level through the flop chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// sig_debounce: synchronizer + 4-state debounce FSM with edge pulses.
// Optional rise counter under `SIG_DEBOUNCE_EDGE_CNT_EN.
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
  ,
  input  logic       edge_cnt_clr,
  output logic [7:0] edge_cnt
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dout_n, rise_n, fall_n;

  sig_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (din),
    .q    (s)
  );

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= STABLE_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // next state: the entry cycle counts as sample 0, so
  // the level must hold DEBOUNCE_CYCLES+1 FSM samples
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s) begin
          state_n = CHK_HI;
          cnt_n   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          dout_n  = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_n = CHK_LO;
          cnt_n   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          dout_n  = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
        dout_n  = 1'b0;
      end
    endcase
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
  // count rises, clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             edge_cnt <= 8'h00;
    else if (edge_cnt_clr) edge_cnt <= 8'h00;
    else if (rise_n)       edge_cnt <= edge_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sig_debounce.sv
// tb_sig_debounce: random + directed stimulus, queue scoreboard.
// Reference model: run-length of delayed din versus debounced level.
module tb_sig_debounce;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int LAT = SS + DC;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din = 1'b0;
  logic dout, rise, fall, busy;
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
  logic       clr = 1'b0;
  logic [7:0] edge_cnt;
`endif

  always #5 clk = ~clk;

  sig_debounce #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
    ,
    .edge_cnt_clr (clr),
    .edge_cnt     (edge_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nrise = 0;

  typedef struct {
    bit up;
    int at;
  } ev_t;

  ev_t evq[$];
  bit  mq[$];
  bit  m_dout;
  int  run;
  int  mcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // model: din delayed SS edges must differ from level
  // for DC+1 consecutive edges to flip it
  always @(posedge clk) begin : model
    bit s;
    cyc++;
    if (!rstn) begin
      mq = {};
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
      m_dout = 1'b0;
      run = 0;
      mcnt = 0;
    end else begin
      s = mq.pop_front();
      mq.push_back(din);
      if (s != m_dout) begin
        run++;
        if (run == DC + 1) begin
          m_dout = ~m_dout;
          evq.push_back('{up: m_dout, at: cyc});
          run = 0;
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
          if (m_dout) mcnt = (mcnt + 1) % 256;
`endif
        end
      end else begin
        run = 0;
      end
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
      if (clr) mcnt = 0;
`endif
    end
  end

  // monitor: pops expected pulses as the DUT emits them
  always @(posedge clk) begin : monitor
    ev_t e;
    #2;
    if (rise) nrise++;
    if (rise || fall) begin
      if (evq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_pulse: got rise=%0d fall=%0d want none (cycle %0d)",
                 rise, fall, cyc);
      end else begin
        e = evq.pop_front();
        chk("pulse_kind", rise, e.up);
        chk("pulse_cycle", cyc, e.at);
      end
    end else if (evq.size() > 0 && evq[0].at <= cyc) begin
      e = evq.pop_front();
      total++;
      bad++;
      $display("FAIL missed_pulse: got none want up=%0d at %0d (cycle %0d)",
               e.up, e.at, cyc);
    end
    chk("rise_fall_excl", rise & fall, 0);
    chk("dout", dout, m_dout);
    chk("busy", busy, run > 0);
`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
    chk("edge_cnt", edge_cnt, mcnt);
`endif
  end

  task automatic set(input logic v);
    @(negedge clk);
    din = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input bit up, input int start,
                            input string nm);
    int lat;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #3;
      if (up ? rise : fall) begin
        lat = cyc - start;
        break;
      end
    end
    chk(nm, lat, LAT);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int start;
    int n0;
    rstn = 1'b0;
    din  = 1'b1;
    hold(3);
    chk("rst_dout", dout, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_busy", busy, 0);
    din = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    hold(5);

    set(1'b1);
    start = cyc + 1;
    wait_pulse(1'b1, start, "step_rise_lat");
    hold(4);
    chk("step_dout", dout, 1);

    set(1'b0);
    start = cyc + 1;
    wait_pulse(1'b0, start, "fall_lat");
    hold(4);
    chk("fall_dout", dout, 0);

    n0 = nrise;
    set(1'b1);
    hold(2);
    din = 1'b0;
    hold(10);
    chk("glitch_dout", dout, 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_norise", nrise - n0, 0);

    n0 = nrise;
    for (int i = 0; i < 10; i++) set((i % 2) == 0);
    set(1'b1);
    start = cyc + 1;
    wait_pulse(1'b1, start, "bounce_lat");
    hold(8);
    chk("bounce_one_rise", nrise - n0, 1);

    set(1'b0);
    hold(12);
    set(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (busy) break;
    end
    chk("mid_busy_seen", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rise", rise, 0);
    chk("mid_rst_fall", fall, 0);
    @(negedge clk);
    rstn = 1'b1;
    start = cyc + 1;
    wait_pulse(1'b1, start, "post_rst_lat");
    hold(4);

    for (int i = 0; i < 60; i++) begin
      set(1'($urandom_range(0, 1)));
      hold($urandom_range(0, 8));
    end
    set(1'b0);
    hold(20);
    chk("queue_drained", evq.size(), 0);
    chk("final_dout", dout, 0);

`ifdef SIG_DEBOUNCE_EDGE_CNT_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      set(1'b1);
      hold(8);
      set(1'b0);
      hold(8);
    end
    chk("cnt_wrap", edge_cnt, 1);
    set(1'b1);
    hold(LAT - 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_on_rise_dout", dout, 1);
    chk("clr_on_rise", edge_cnt, 0);
    set(1'b0);
    hold(12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
